full_adder: RTL and testbench



---
 rtl/full_adder_pkg.sv | 11 +
 rtl/full_adder_cell.sv | 16 +
 rtl/full_adder.sv | 56 +++++
 tb/tb_full_adder.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// rtl/full_adder_pkg.sv - shared width constant and result type for full_adder
package full_adder_pkg;

    localparam int FA_DEFAULT_WIDTH = 4;

    typedef struct packed {
        logic                        cout;
        logic [FA_DEFAULT_WIDTH-1:0] sum;
    } fa_result_t;

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - combinational 1-bit full adder cell
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - registered ripple-carry adder; optional ovf output via FULL_ADDER_OVF_EN
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
`ifdef FULL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = cin;

    // Carry ripples LSB to MSB through one cell per bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= s;
            cout <= c[WIDTH];
        end
    end

`ifdef FULL_ADDER_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else begin
            ovf <= c[WIDTH] ^ c[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - randomized self-checking bench for full_adder (WIDTH=4)
module tb_full_adder;
    import full_adder_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
`ifdef FULL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    full_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
`ifdef FULL_ADDER_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic fa_result_t model_add(int unsigned x, int unsigned y, int unsigned ci);
        fa_result_t  r;
        int unsigned t;
        t      = x + y + ci;
        r.sum  = W'(t % (1 << W));
        r.cout = (t >= (1 << W));
        return r;
    endfunction

    function automatic logic model_ovf(int unsigned x, int unsigned y, int unsigned ci);
        int sx;
        int sy;
        int t;
        sx = (x >= (1 << (W-1))) ? int'(x) - (1 << W) : int'(x);
        sy = (y >= (1 << (W-1))) ? int'(y) - (1 << W) : int'(y);
        t  = sx + sy + int'(ci);
        return (t > (1 << (W-1)) - 1) || (t < -(1 << (W-1)));
    endfunction

    task automatic do_op(input string tag, input int unsigned x, input int unsigned y,
                         input int unsigned ci, input logic rst);
        fa_result_t exp;
        logic       exp_ovf;
        a     = W'(x);
        b     = W'(y);
        cin   = ci[0];
        rst_n = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            exp     = model_add(x, y, ci);
            exp_ovf = model_ovf(x, y, ci);
        end else begin
            exp     = '0;
            exp_ovf = 1'b0;
        end
        check({tag, ".sum"}, 32'(sum), 32'(exp.sum));
        check({tag, ".cout"}, 32'(cout), 32'(exp.cout));
`ifdef FULL_ADDER_OVF_EN
        check({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) failures++;
`endif
    endtask

    task automatic expect_const(input string tag, input int unsigned x, input int unsigned y,
                                input int unsigned ci, input int unsigned es, input int unsigned ec);
        do_op(tag, x, y, ci, 1'b1);
        check({tag, ".sum_lit"}, 32'(sum), es);
        check({tag, ".cout_lit"}, 32'(cout), ec);
    endtask

    initial begin
        int unsigned va [4] = '{3, 2, 9, 10};
        int unsigned vb [4] = '{4, 5, 9, 15};
        int unsigned s1 [4] = '{8, 8, 3, 10};
        int unsigned c1 [4] = '{0, 0, 1, 1};
        int unsigned s0 [4] = '{7, 7, 2, 9};

        do_op("rst0", 3, 4, 1, 1'b0);
        do_op("rst1", 3, 4, 1, 1'b0);
        expect_const("post_rst", 3, 4, 1, 8, 0);

        for (int i = 0; i < 4; i++) expect_const("cin1", va[i], vb[i], 1, s1[i], c1[i]);
        for (int i = 0; i < 4; i++) expect_const("cin0", va[i], vb[i], 0, s0[i], c1[i]);

        expect_const("max", 15, 15, 1, 15, 1);
        expect_const("zero", 0, 0, 0, 0, 0);
        expect_const("wrap", 15, 0, 1, 0, 1);

`ifdef FULL_ADDER_OVF_EN
        do_op("ovf_pos", 7, 1, 0, 1'b1);
        check("ovf_pos.lit", 32'(ovf), 1);
        do_op("ovf_neg", 8, 8, 0, 1'b1);
        check("ovf_neg.lit", 32'(ovf), 1);
        check("ovf_neg.sum_lit", 32'(sum), 0);
        check("ovf_neg.cout_lit", 32'(cout), 1);
        do_op("ovf_none", 3, 4, 0, 1'b1);
        check("ovf_none.lit", 32'(ovf), 0);
`endif

        expect_const("mid_a", 3, 4, 0, 7, 0);
        do_op("mid_rst", 2, 5, 1, 1'b0);
        check("mid_rst.sum_lit", 32'(sum), 0);
        expect_const("mid_b", 9, 9, 0, 2, 1);
        // cin alone changes with operands held
        expect_const("cin_only", 9, 9, 1, 3, 1);

        for (int i = 0; i < 1000; i++) begin
            do_op("rand", $urandom_range(15), $urandom_range(15), $urandom_range(1),
                  ($urandom_range(19) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
